// File: rtl/adder_arbiter.sv
// Two-requester round-robin front end for a shared multi-cycle adder.
// Optional WAIT watchdog and err output are enabled by defining ADDER_ARB_TIMEOUT_EN.
module adder_arbiter #(
    parameter int WIDTH = 513
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             req0,
    input  logic             req1,
    input  logic             sub0,
    input  logic             sub1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             ack0,
    output logic             ack1,
    output logic [WIDTH:0]   result,
    output logic             busy,
    output logic             add_start,
    output logic             add_subtract,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    input  logic [WIDTH:0]   add_result,
    input  logic             add_done
`ifdef ADDER_ARB_TIMEOUT_EN
    ,
    output logic             err
`endif
);

    // state | meaning
    // IDLE  | no operation, arbitrate requests
    // ISSUE | add_start pulse to the shared adder
    // WAIT  | waiting for add_done (or watchdog expiry)
    // RESP  | ack pulse to the granted requester
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t state;
    logic   last;
    logic   id;
    logic   grant;

`ifdef ADDER_ARB_TIMEOUT_EN
    logic [7:0] wait_cnt;
    logic       expired;
`endif

    // On a tie the requester not served last wins; a lone request always wins.
    always_comb begin
        grant = (req0 && req1) ? ~last : req1;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= IDLE;
            last         <= 1'b1;
            id           <= 1'b0;
            ack0         <= 1'b0;
            ack1         <= 1'b0;
            result       <= '0;
            busy         <= 1'b0;
            add_start    <= 1'b0;
            add_subtract <= 1'b0;
            add_a        <= '0;
            add_b        <= '0;
`ifdef ADDER_ARB_TIMEOUT_EN
            wait_cnt     <= '0;
            expired      <= 1'b0;
            err          <= 1'b0;
`endif
        end else begin
            add_start <= 1'b0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
`ifdef ADDER_ARB_TIMEOUT_EN
            err       <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        state        <= ISSUE;
                        busy         <= 1'b1;
                        add_start    <= 1'b1;
                        id           <= grant;
                        last         <= grant;
                        add_a        <= grant ? a1 : a0;
                        add_b        <= grant ? b1 : b0;
                        add_subtract <= grant ? sub1 : sub0;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
`ifdef ADDER_ARB_TIMEOUT_EN
                    wait_cnt <= '0;
                    expired  <= 1'b0;
`endif
                end
                WAIT: begin
`ifdef ADDER_ARB_TIMEOUT_EN
                    // Once 256 WAIT cycles have elapsed the watchdog wins over a late add_done.
                    if (expired) begin
                        state  <= RESP;
                        result <= '0;
                        err    <= 1'b1;
                        ack0   <= ~id;
                        ack1   <= id;
                    end else if (add_done) begin
                        state  <= RESP;
                        result <= add_result;
                        ack0   <= ~id;
                        ack1   <= id;
                    end else if (wait_cnt == 8'hFF) begin
                        expired <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
`else
                    if (add_done) begin
                        state  <= RESP;
                        result <= add_result;
                        ack0   <= ~id;
                        ack1   <= id;
                    end
`endif
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 513, operand width of the shared adder; the result width is WIDTH+1.
REQ-002 The block SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-003 The block SHALL have port resetn, input, 1, with reset resetn synchronous and active-low.
REQ-004 The block SHALL have ports req0 and req1, input, 1 each, requester level request, held high until the matching ack.
REQ-005 The block SHALL have ports sub0 and sub1, input, 1 each, requester operation select: 0 = add, 1 = subtract.
REQ-006 The block SHALL have ports a0, b0, a1 and b1, input, WIDTH each, requester operands.
REQ-007 The block SHALL have ports ack0 and ack1, output, 1 each, one-cycle completion pulse to each requester.
REQ-008 The block SHALL have port result, output, WIDTH+1, registered adder result, valid in the ack cycle and held until the next completion.
REQ-009 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-010 The block SHALL have ports add_start (output, 1), add_subtract (output, 1), add_a (output, WIDTH) and add_b (output, WIDTH), which drive the shared adder.
REQ-011 The block SHALL have ports add_result (input, WIDTH+1) and add_done (input, 1), the shared adder's outputs.
REQ-012 The block SHALL have port err, output, 1, timeout flag pulsed with ack; it exists only with the macro (see Configuration).

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT, RESP.
- IDLE -> ISSUE when any req is high.
- ISSUE -> WAIT unconditionally.
- WAIT -> RESP on add_done.
- RESP -> IDLE unconditionally.
REQ-014 Arbitration SHALL be round-robin:
- When only one req is high in IDLE, that requester is granted.
- When both are high, the requester not served last is granted.
- The last-served pointer resets to 1, so requester 0 wins the first tie.
REQ-015 On the IDLE->ISSUE edge the block SHALL capture the granted requester's operands, sub bit and id into internal registers; later changes on that requester's inputs SHALL be ignored.
REQ-016 add_start SHALL be high for exactly one cycle, in ISSUE; add_a, add_b and add_subtract SHALL present the captured values from ISSUE through WAIT.
REQ-017 add_done SHALL be ignored in IDLE, ISSUE and RESP.
REQ-018 In the cycle add_done is sampled high in WAIT, result SHALL load add_result; the granted ackN SHALL be high for exactly the following (RESP) cycle.
REQ-019 Latency SHALL be 3 + D cycles from the first IDLE cycle with req high to the ack cycle, where D = cycles from add_start to add_done (D>=1).
REQ-020 A requester SHALL drop req on the edge at which it samples ack; the arbiter samples req again only in IDLE, so back-to-back requests never double-serve.
REQ-021 A req dropped before ack SHALL NOT abort the operation; the ack SHALL still be issued.
REQ-022 Requests arriving while busy SHALL wait and be arbitrated at the next IDLE; ack0 and ack1 SHALL never be high together.

Reset
REQ-023 With resetn low at a clock edge, the block SHALL enter IDLE and set ack0, ack1, add_start, add_subtract, busy and err to 0, add_a, add_b and result to 0, and the pointer to 1.
REQ-024 A reset mid-operation SHALL discard the operation without any ack; adder outputs arriving after reset SHALL be ignored.

Configuration
REQ-025 Macro ADDER_ARB_TIMEOUT_EN SHALL control the WAIT-state watchdog:
- Defined: an 8-bit counter clears on entry to WAIT and counts each WAIT cycle. If 256 WAIT cycles pass without add_done, the FSM goes to RESP with result = 0 and err high alongside the ack. A later stray add_done is ignored.
- Undefined: no counter and no err port; WAIT lasts indefinitely.

Verification
REQ-026 req0=1, sub0=0, a0=5, b0=3, adder model D=3 -> add_start one pulse; ack0 at cycle 6; result=8; ack1 never high.
REQ-027 req0 and req1 rise together from reset (a1=10, b1=4, sub1=1), each requester drops req on its ack -> requester 0 served first, then requester 1 with result=6; order 0,1.
REQ-028 Both reqs held continuously for 4 transactions -> acks alternate 0,1,0,1; acks are never simultaneous.
REQ-029 a0=all ones, b0=1, add -> result = 2^WIDTH; a0 changed in WAIT -> result unaffected.
REQ-030 resetn low during WAIT, then add_done arrives -> no ack, busy=0, result=0; the next request completes normally.
REQ-031 With ADDER_ARB_TIMEOUT_EN defined and add_done never asserted -> ack0 and err high 258 cycles after ISSUE, result=0.
